// File: rtl/contextual_decoder_upsample_pkg.sv
// Shared types and saturating arithmetic for the contextual decoder stages.
// Pixel widths up to SAT_W bits are supported by sat_add.
package ctx_dec_pkg;

    typedef enum logic {FILL = 1'b0, REPLAY = 1'b1} state_t;

    localparam int SAT_W = 32;
    localparam int ACC_W = 2 * SAT_W + 1;

    // Returns min(prod + bias, 2^dw - 1); the extra accumulator bit keeps the sum from wrapping.
    function automatic logic [SAT_W-1:0] sat_add(input logic [2*SAT_W-1:0] prod,
                                                 input logic [SAT_W-1:0]   bias,
                                                 input int                 dw);
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] lim;
        acc = ACC_W'(prod) + ACC_W'(bias);
        lim = (ACC_W'(1) << dw) - ACC_W'(1);
        if (acc > lim)
            return lim[SAT_W-1:0];
        return acc[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/contextual_decoder_upsample_line_buffer.sv
// One-row pixel store for regenerating odd output rows.
// Synchronous write, registered read; the caller presents the read address a cycle early.
module deconv_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [WIDTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/contextual_decoder_upsample.sv
// Streaming 2x2 stride-2 transposed convolution: each input pixel becomes a 2x2 output block.
// Counters (state, row, col, b) name the next output to be loaded into the output register.
module contextual_decoder_upsample
    import ctx_dec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*DATA_WIDTH-1:0] weights,
    input  logic [DATA_WIDTH-1:0]   bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_sof,
    output logic                    out_last
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    state_t                  state_reg, state_next;
    logic [CW-1:0]           col_reg, col_next;
    logic [RW-1:0]           row_reg, row_next;
    logic                    b_reg, b_next;
    logic [DATA_WIDTH-1:0]   pix_reg, pix_next;
    logic                    out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic                    out_sof_reg, out_sof_next;
    logic                    out_last_reg, out_last_next;

    logic [DATA_WIDTH-1:0]   taps [4];
    logic [1:0]              tap_idx;
    logic [DATA_WIDTH-1:0]   tap;
    logic [DATA_WIDTH-1:0]   src;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [CW-1:0]           rd_addr;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   result;
    logic                    can_load;
    logic                    load;
    logic                    buf_we;

    for (genvar gi = 0; gi < 4; gi++) begin : g_taps
        assign taps[gi] = weights[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign tap_idx  = {state_reg == REPLAY, b_reg};
    assign tap      = taps[tap_idx];
    assign can_load = !out_valid_reg || out_ready;
    assign in_ready = (state_reg == FILL) && !b_reg && can_load;
    assign buf_we   = in_valid && in_ready;
    assign load     = can_load && (b_reg || state_reg == REPLAY || in_valid);

    // Point the read port at the column the next REPLAY b=0 load will need.
    assign rd_addr = !b_reg ? col_reg : ((col_reg == COL_MAX) ? '0 : col_reg + CW'(1));

    always_comb begin
        src = pix_reg;
        if (!b_reg)
            src = (state_reg == FILL) ? in_data : rd_data;
    end

    assign prod   = (2*DATA_WIDTH)'(src) * (2*DATA_WIDTH)'(tap);
    assign result = DATA_WIDTH'(sat_add((2*SAT_W)'(prod), SAT_W'(bias), DATA_WIDTH));

    deconv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WIDTH      (WIDTH),
        .AW         (CW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (col_reg),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        b_next         = b_reg;
        pix_next       = pix_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_sof_next   = out_sof_reg;
        out_last_next  = out_last_reg;
        if (can_load)
            out_valid_next = load;
        if (load) begin
            out_data_next = result;
            out_sof_next  = (row_reg == '0) && (state_reg == FILL) && (col_reg == '0) && !b_reg;
            out_last_next = (row_reg == ROW_MAX) && (state_reg == REPLAY) && (col_reg == COL_MAX) && b_reg;
            b_next        = !b_reg;
            if (!b_reg) begin
                pix_next = src;
            end else if (col_reg == COL_MAX) begin
                // Switch mode as the row's final output is loaded so the next row starts without a bubble.
                col_next = '0;
                if (state_reg == FILL) begin
                    state_next = REPLAY;
                end else begin
                    state_next = FILL;
                    row_next   = (row_reg == ROW_MAX) ? '0 : row_reg + RW'(1);
                end
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FILL;
            col_reg       <= '0;
            row_reg       <= '0;
            b_reg         <= 1'b0;
            pix_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sof_reg   <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            b_reg         <= b_next;
            pix_reg       <= pix_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sof_reg   <= out_sof_next;
            out_last_reg  <= out_last_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sof   = out_sof_reg;
    assign out_last  = out_last_reg;

endmodule

// File: doc/contextual_decoder_upsample.md
# contextual_decoder_upsample

Streaming 2x spatial upsampler for the contextual decoder path. It is the inverse of the encoder's stride-2 downsampling conv stage. It applies a single-channel, non-overlapping 2x2 transposed convolution with stride 2, so each input pixel produces one 2x2 output block. It consumes a raster-ordered HEIGHT x WIDTH feature map and emits a raster-ordered 2*HEIGHT x 2*WIDTH map. Both sides use valid/ready handshakes, and one input row is buffered internally to regenerate the odd output rows.

## Interface
- DATA_WIDTH, 8, pixel/weight/bias width; all values are unsigned.
- HEIGHT, 8, input rows per frame.
- WIDTH, 8, input pixels per row.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- weights  in  4*DATA_WIDTH  tap (a,b) at bits [(2a+b)*DATA_WIDTH +: DATA_WIDTH]; a = output row parity, b = output column parity; must be static while a frame is in progress.
- bias  in  DATA_WIDTH  added to every product; static during a frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  input pixel, raster order.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  DATA_WIDTH  output pixel, raster order.
- out_sof  out  1  high with the first output pixel of a frame.
- out_last  out  1  high with the final output pixel (2H-1, 2W-1).

## Operation
- Output arithmetic: out(2i+a, 2j+b) = min(in(i,j)*w(a,b) + bias, 2^DATA_WIDTH-1).
  - Products are 2*DATA_WIDTH bits; the accumulator is 2*DATA_WIDTH+1 bits; the result saturates, never wraps.
- State FILL (input row i, output row 2i):
  - Each accepted pixel is written to row_buf[col] and held in a pixel register.
  - It produces two outputs: b=0, then b=1, both using taps a=0.
  - After the b=1 output of col WIDTH-1 handshakes, the FSM goes to REPLAY.
- State REPLAY (output row 2i+1):
  - in_ready=0.
  - For col 0..WIDTH-1, read row_buf[col] and emit b=0 then b=1 using taps a=1.
  - After the last handshake: if row i = HEIGHT-1, clear row/col counters and go to FILL (next frame); otherwise row++ and go to FILL.
- The out_valid/out_data/out_sof/out_last register holds stable until out_ready is seen (no dropping, no change under backpressure).
- Counters: col (log2 WIDTH), row (log2 HEIGHT), phase b (1 bit). All wrap exactly at their limits.
- out_sof = (row==0 && a==0 && col==0 && b==0). out_last = (row==HEIGHT-1 && a==1 && col==WIDTH-1 && b==1).

## Timing
- Reset values: state=FILL; row=col=b=0; out_valid=0; out_data=0; out_sof=0; out_last=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-frame: the partial frame is discarded; the next accepted pixel is pixel (0,0). row_buf contents are not reset.
- Latency: input accepted in cycle t gives its b=0 output valid in cycle t+1.
- in_ready = (state==FILL) && (!out_valid || (out_ready && b==1)).
  - The next pixel is accepted in the same cycle that the previous pixel's b=1 output handshakes.
  - With in_valid and out_ready held high, output runs at 1 pixel/cycle with no bubbles, including across FILL/REPLAY and frame boundaries.
- Input throughput is at most 1 pixel per 2 cycles in FILL and 0 in REPLAY.
- A frame takes 4*HEIGHT*WIDTH output cycles minimum.
- When out_ready=0, all outputs are frozen, in_ready=0, and the counters hold.

## Structure
- Package ctx_dec_pkg holds:
  - the state enum {FILL, REPLAY};
  - the accumulator width constant;
  - a sat_add function (product + bias, clamped to DATA_WIDTH), shared with the other decoder stages.
- Sub-module deconv_line_buffer: WIDTH x DATA_WIDTH, one write port and one read port, synchronous write, combinational or registered read. The read address is pre-fetched one cycle ahead to hide the registered-read latency.
- The top level contains the FSM, counters, arithmetic and output register.

## Test plan
- Arithmetic: in_data=3 everywhere, weights={w00=1,w01=2,w10=3,w11=4}, bias=5 -> even rows alternate 8,11 and odd rows alternate 14,17.
- Saturation: in_data=255, all weights=255, bias=0 -> every output is 255. Also in_data=0, bias=7 -> every output is 7.
- Frame framing (8x8, in_data=row*8+col, w=1, bias=0):
  - 256 outputs; out(r,c) = in(r/2, c/2);
  - out_sof only on output 1 and out_last only on output 256;
  - the second frame back-to-back repeats with no bubble.
- Backpressure: random out_ready (50%) and random in_valid:
  - the output sequence is identical to the no-stall run;
  - out_data is stable while out_valid && !out_ready;
  - in_ready is never high in REPLAY.
- Reset mid-frame: assert rst during REPLAY of row 3.
  - The next cycle shows out_valid=0.
  - After release, the new frame's first output carries out_sof=1 and uses in(0,0).
